instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameters: none; all widths fixed (RV32I, 32-bit words, 32-bit addresses).
REQ-002 Reset and clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  synchronous restart: load address, clear count.
REQ-006 base_addr  in  32  first write address, sampled when start=1.
REQ-007 in_valid  in  1  instruction fields valid.
REQ-008 in_ready  out  1  encoder accepts fields this cycle.
REQ-009 op_class  in  3  0=R, 1=I-ALU, 2=JALR, 3=LW, 4=SW, 5=B, 6=LUI, 7=JAL.
REQ-010 funct3  in  3, funct7  in  7, rd/rs1/rs2  in  5 each, imm  in  32  instruction fields.
REQ-011 mem_we  out  1  encoded word valid toward instruction memory.
REQ-012 mem_ready  in  1  memory accepts word; a write completes when mem_we and mem_ready are both 1.
REQ-013 mem_addr  out  32, mem_wdata  out  32  write address and encoded instruction.
REQ-014 count  out  16  number of completed writes since reset/start, saturating.
REQ-015 err  out  1  sticky encoding-error flag (see Configuration).

Function
REQ-016 Acceptance occurs on a rising edge when in_valid and in_ready are both 1; in_ready = !start && (!mem_we || mem_ready).
REQ-017 The accepted word SHALL appear on mem_wdata with mem_we=1 in the cycle after acceptance (1-cycle latency), held in an output register.
REQ-018 While mem_we=1 and mem_ready=0, mem_we, mem_addr and mem_wdata SHALL hold stable.
REQ-019 Back-to-back: with mem_ready=1, one word SHALL be written per cycle, no bubbles.
REQ-020 Encodings [31:0], per op_class:
 - R: funct7|rs2|rs1|funct3|rd|0110011.
 - I-ALU: imm[11:0]|rs1|funct3|rd|0010011.
 - JALR: imm[11:0]|rs1|000|rd|1100111 (funct3 forced).
 - LW: imm[11:0]|rs1|010|rd|0000011.
 - SW: imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
 - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011.
 - LUI: imm[31:12]|rd|0110111.
 - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
REQ-021 Unused field inputs SHALL be ignored.
REQ-022 mem_addr SHALL increment by 4 on each completed write, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-023 count SHALL increment on each completed write and saturate at 0xFFFF.
REQ-024 start=1: next edge loads mem_addr=base_addr and count=0, and discards any pending output word (mem_we=0); start takes priority over acceptance and write completion in the same cycle.
REQ-025 start without a prior start after reset: address begins at 0x00000000.

Reset
REQ-026 rst_n=0 SHALL immediately force mem_we=0, mem_addr=0, mem_wdata=0, count=0 and err=0, and drop any pending word; in_ready=1 from the first cycle after rst_n rises (start=0).
REQ-027 Reset asserted mid-write SHALL abandon the write, with no partial update.

Configuration
REQ-028 Macro ENC_CHECK_EN: when defined, an accepted instruction is illegal if either:
 - B/JAL imm[0]!=0, or B imm is not 13-bit sign-extended, or JAL imm is not 21-bit sign-extended;
 - I-ALU/JALR/LW/SW imm is not 12-bit sign-extended, or LUI imm[11:0]!=0.
REQ-029 With ENC_CHECK_EN: an illegal instruction is consumed (handshake completes), produces no write, sets err=1 until reset or start, and does not advance mem_addr or count.
REQ-030 Without ENC_CHECK_EN: no checks; err is tied 0; excess imm bits are silently truncated.

Verification
REQ-031 Reset, start with base_addr=0x100, then R op rd=3 rs1=1 rs2=2 funct3=0 funct7=0 -> mem_wdata=0x002081B3 at mem_addr=0x100, one cycle after accept.
REQ-032 LUI rd=5 imm=0x12345000, then SW rs1=1 rs2=2 imm=8, back-to-back with mem_ready=1 -> 0x123452B7 @0x100, 0x0020A423 @0x104, count=2.
REQ-033 JAL rd=1 imm=8 with mem_ready low for 3 cycles -> 0x008000EF held stable, in_ready=0 for 3 cycles, count increments once.
REQ-034 base_addr=0xFFFFFFFC, two writes -> addresses 0xFFFFFFFC then 0x00000000; start asserted while a word is pending -> word dropped, count=0.
REQ-035 ENC_CHECK_EN defined, B op imm=0x3 -> accepted, mem_we stays 0, err=1; same stimulus without the macro -> word written, err=0.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Instruction-field request channel and instruction-memory write channel of instr_encoder.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op_class;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;
   logic        mem_we;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   modport master (
      output in_valid, op_class, funct3, funct7, rd, rs1, rs2, imm, mem_ready,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_valid, op_class, funct3, funct7, rd, rs1, rs2, imm, mem_ready,
      output in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into 32-bit words and streams them to memory.
// Optional macro ENC_CHECK_EN enables immediate-legality checking and the sticky err flag.
module instr_encoder (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [31:0]          base_addr,
   instr_encoder_if.slave       bus,
   output logic [15:0]          count,
   output logic                 err
);
   logic        mem_we_q,    mem_we_d;
   logic [31:0] mem_addr_q,  mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [15:0] count_q,     count_d;
   logic [31:0] enc_word;
   logic        illegal;
   logic        in_ready;
   logic        accept;
   logic        write_done;

   assign in_ready   = !start && (!mem_we_q || bus.mem_ready);
   assign accept     = bus.in_valid && in_ready;
   assign write_done = mem_we_q && bus.mem_ready;

   always_comb begin
      enc_word = 32'h0;
      case (bus.op_class)
         3'd0: enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, 7'b0110011};
         3'd1: enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, 7'b0010011};
         3'd2: enc_word = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, 7'b1100111};
         3'd3: enc_word = {bus.imm[11:0], bus.rs1, 3'b010, bus.rd, 7'b0000011};
         3'd4: enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, 3'b010, bus.imm[4:0], 7'b0100011};
         3'd5: enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                           bus.imm[4:1], bus.imm[11], 7'b1100011};
         3'd6: enc_word = {bus.imm[31:12], bus.rd, 7'b0110111};
         3'd7: enc_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                           bus.rd, 7'b1101111};
         default: enc_word = 32'h0;
      endcase
   end

`ifdef ENC_CHECK_EN
   logic err_q, err_d;

   // Immediates must be the sign extension of the field width the format can carry.
   always_comb begin
      illegal = 1'b0;
      case (bus.op_class)
         3'd1, 3'd2, 3'd3, 3'd4: illegal = (bus.imm[31:12] != {20{bus.imm[11]}});
         3'd5: illegal = bus.imm[0] || (bus.imm[31:13] != {19{bus.imm[12]}});
         3'd6: illegal = (bus.imm[11:0] != 12'h000);
         3'd7: illegal = bus.imm[0] || (bus.imm[31:21] != {11{bus.imm[20]}});
         default: illegal = 1'b0;
      endcase
   end

   always_comb begin
      err_d = err_q;
      if (start)                  err_d = 1'b0;
      else if (accept && illegal) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign err = err_q;
`else
   assign illegal = 1'b0;
   assign err     = 1'b0;
`endif

   always_comb begin
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      count_d     = count_q;
      if (start) begin
         mem_we_d   = 1'b0;
         mem_addr_d = base_addr;
         count_d    = 16'h0000;
      end else begin
         if (write_done) begin
            mem_we_d   = 1'b0;
            mem_addr_d = mem_addr_q + 32'd4;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
         end
         // A new legal word replaces the one just completed in the same cycle.
         if (accept && !illegal) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = enc_word;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         count_q     <= 16'h0000;
      end else begin
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         count_q     <= count_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign count         = count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver pushes expected writes, a negedge monitor pops them.
module tb_instr_encoder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [31:0] base_addr = 32'h0;
   logic [15:0] count;
   logic        err;

   instr_encoder_if bus ();

   instr_encoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .bus       (bus),
      .count     (count),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_addr = 32'h0;
   int          exp_count = 0;
   bit          exp_err = 1'b0;
   bit          rand_ready = 1'b0;
   bit          hold = 1'b0;
   logic [31:0] hold_addr, hold_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] ref_enc(input logic [2:0] oc, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [4:0] rdv,
                                           input logic [4:0] r1, input logic [4:0] r2,
                                           input logic [31:0] iv);
      case (oc)
         3'd0: return {f7, r2, r1, f3, rdv, 7'h33};
         3'd1: return {iv[11:0], r1, f3, rdv, 7'h13};
         3'd2: return {iv[11:0], r1, 3'd0, rdv, 7'h67};
         3'd3: return {iv[11:0], r1, 3'd2, rdv, 7'h03};
         3'd4: return {iv[11:5], r2, r1, 3'd2, iv[4:0], 7'h23};
         3'd5: return {iv[12], iv[10:5], r2, r1, f3, iv[4:1], iv[11], 7'h63};
         3'd6: return {iv[31:12], rdv, 7'h37};
         default: return {iv[20], iv[10:1], iv[11], iv[19:12], rdv, 7'h6F};
      endcase
   endfunction

   // Range-based legality: the immediate, read as a signed number, must fit the format.
   function automatic bit ref_illegal(input logic [2:0] oc, input logic [31:0] iv);
`ifdef ENC_CHECK_EN
      longint s;
      s = longint'($signed(iv));
      case (oc)
         3'd1, 3'd2, 3'd3, 3'd4: return (s < -2048) || (s > 2047);
         3'd5: return (iv % 2 != 0) || (s < -4096) || (s > 4095);
         3'd6: return (iv % 4096 != 0);
         3'd7: return (iv % 2 != 0) || (s < -1048576) || (s > 1048575);
         default: return 1'b0;
      endcase
`else
      return (oc == 3'd0) && (iv == 32'h1) && 1'b0;
`endif
   endfunction

   function automatic logic [31:0] gen_imm(input logic [2:0] oc);
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 3) == 0) return r;
      case (oc)
         3'd5: return {{19{r[12]}}, r[12:1], 1'b0};
         3'd6: return {r[31:12], 12'h000};
         3'd7: return {{11{r[20]}}, r[20:1], 1'b0};
         default: return {{20{r[11]}}, r[11:0]};
      endcase
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         hold = 1'b0;
      end else begin
         check("count", {16'h0, count}, exp_count[31:0]);
         check("err", {31'h0, err}, {31'h0, exp_err});
         if (hold) begin
            check("stall_we", {31'h0, bus.mem_we}, 32'h1);
            check("stall_addr", bus.mem_addr, hold_addr);
            check("stall_data", bus.mem_wdata, hold_data);
         end
         hold = 1'b0;
         if (bus.mem_we && !bus.mem_ready && !start) begin
            hold = 1'b1;
            hold_addr = bus.mem_addr;
            hold_data = bus.mem_wdata;
         end
         if (bus.mem_we && bus.mem_ready && !start) begin
            if (sb.size() == 0) begin
               check("unexpected_write", bus.mem_wdata, 32'hDEAD_BEEF);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("wr_addr", bus.mem_addr, e.addr);
               check("wr_data", bus.mem_wdata, e.data);
            end
            if (exp_count < 65535) exp_count++;
         end
      end
   end

   initial begin
      bus.mem_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (rand_ready) bus.mem_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Called at posedge+2; returns at posedge+2 with in_valid low.
   task automatic send(input logic [2:0] oc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rdv, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] iv, input bit gold, input logic [31:0] gw);
      bit          acc;
      logic [31:0] w;
      bus.in_valid = 1'b1;
      bus.op_class = oc;
      bus.funct3   = f3;
      bus.funct7   = f7;
      bus.rd       = rdv;
      bus.rs1      = r1;
      bus.rs2      = r2;
      bus.imm      = iv;
      acc = 1'b0;
      for (int i = 0; i < 64 && !acc; i++) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         if (!acc) #1;
      end
      if (!acc) begin
         check("accept_timeout", 32'h0, 32'h1);
         bus.in_valid = 1'b0;
         return;
      end
      w = gold ? gw : ref_enc(oc, f3, f7, rdv, r1, r2, iv);
      if (ref_illegal(oc, iv)) begin
         exp_err = 1'b1;
      end else begin
         sb.push_back({exp_addr, w});
         check("lat_we", {31'h0, bus.mem_we}, 32'h1);
         check("lat_data", bus.mem_wdata, w);
         check("lat_addr", bus.mem_addr, exp_addr);
         exp_addr = exp_addr + 32'd4;
      end
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_rand();
      logic [2:0] oc;
      oc = 3'($urandom_range(0, 7));
      send(oc, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           gen_imm(oc), 1'b0, 32'h0);
   endtask

   task automatic do_start(input logic [31:0] b);
      start = 1'b1;
      base_addr = b;
      @(posedge clk);
      #1;
      sb.delete();
      exp_addr = b;
      exp_count = 0;
      exp_err = 1'b0;
      #1;
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_we", {31'h0, bus.mem_we}, 32'h0);
      check("rst_addr", bus.mem_addr, 32'h0);
      check("rst_data", bus.mem_wdata, 32'h0);
      check("rst_count", {16'h0, count}, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      sb.delete();
      exp_addr = 32'h0;
      exp_count = 0;
      exp_err = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
      @(posedge clk);
      #2;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.op_class = 3'd0;
      bus.funct3 = 3'd0;
      bus.funct7 = 7'd0;
      bus.rd = 5'd0;
      bus.rs1 = 5'd0;
      bus.rs2 = 5'd0;
      bus.imm = 32'h0;
      #2;
      @(posedge clk);
      #2;
      do_reset();

      bus.mem_ready = 1'b1;
      send(3'd0, 3'd0, 7'd0, 5'd7, 5'd1, 5'd2, 32'h0, 1'b0, 32'h0);
      idle(2);

      do_start(32'h100);
      send(3'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 32'h002081B3);
      idle(2);

      do_start(32'h100);
      send(3'd6, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123452B7);
      send(3'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'h8, 1'b1, 32'h0020A423);
      idle(2);
      check("b2b_count", {16'h0, count}, 32'd2);

      do_start(32'h200);
      bus.mem_ready = 1'b0;
      send(3'd7, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h8, 1'b1, 32'h008000EF);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_in_ready", {31'h0, bus.in_ready}, 32'h0);
         check("stall_jal", bus.mem_wdata, 32'h008000EF);
         @(posedge clk);
         #2;
      end
      bus.mem_ready = 1'b1;
      idle(2);
      check("jal_count", {16'h0, count}, 32'd1);

      do_start(32'hFFFF_FFFC);
      send(3'd1, 3'd0, 7'd0, 5'd4, 5'd4, 5'd0, 32'h1, 1'b0, 32'h0);
      send(3'd1, 3'd0, 7'd0, 5'd4, 5'd4, 5'd0, 32'h2, 1'b0, 32'h0);
      idle(2);
      check("wrap_addr", bus.mem_addr, 32'h4);

      bus.mem_ready = 1'b0;
      send(3'd3, 3'd0, 7'd0, 5'd9, 5'd2, 5'd0, 32'h10, 1'b0, 32'h0);
      do_start(32'h40);
      @(negedge clk);
      check("drop_we", {31'h0, bus.mem_we}, 32'h0);
      check("drop_count", {16'h0, count}, 32'h0);
      @(posedge clk);
      #2;
      bus.mem_ready = 1'b1;

      do_start(32'h80);
      send(3'd5, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'h3, 1'b0, 32'h0);
      idle(2);
`ifdef ENC_CHECK_EN
      check("chk_err", {31'h0, err}, 32'h1);
      check("chk_count", {16'h0, count}, 32'h0);
`else
      check("nochk_err", {31'h0, err}, 32'h0);
      check("nochk_count", {16'h0, count}, 32'h1);
`endif

      bus.mem_ready = 1'b0;
      send(3'd0, 3'd1, 7'd5, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 32'h0);
      do_reset();

      do_start({$urandom} & 32'hFFFF_FFFC);
      rand_ready = 1'b1;
      for (int n = 0; n < 400; n++) begin
         send_rand();
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         if (n % 100 == 99) do_start({$urandom} & 32'hFFFF_FFFC);
      end
      rand_ready = 1'b0;
      bus.mem_ready = 1'b1;
      idle(5);
      check("sb_drained", sb.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
